emulib_rammodel_tracker_dual: RTL and testbench
===============================================

Name: emulib_rammodel_tracker_dual

Overview:
Next-generation AXI4 slave-side request tracker for the emulated RAM model. Arbitrates AW/AR into one address-request stream and forwards accepted W beats. Limits read and write in-flight transactions separately, with an independent limit for each direction. Checks the W burst length against AWLEN and reports protocol errors through sticky flags. Sits between the DUT AXI master and the RAM-model timing/backend logic.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width (power of 2, >=8)
ID_WIDTH, 4, AXI ID width
MAX_W_INFLIGHT, 8, max outstanding writes (AW accepted, B not yet returned), >=1
MAX_R_INFLIGHT, 8, max outstanding reads (AR accepted, last R not yet returned), >=1
ARB_MODE, 1, 0 = fixed priority (AW wins), 1 = round-robin

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
axi_aw{valid,id,addr,len,size,burst}  in  1/ID/ADDR/8/3/2  AXI AW payload
axi_awready  out  1  AW accept
axi_w{valid,data,strb,last}  in  1/DATA/DATA/8/1  AXI W payload
axi_wready  out  1  W accept
axi_ar{valid,id,addr,len,size,burst}  in  1/ID/ADDR/8/3/2  AXI AR payload
axi_arready  out  1  AR accept
axi_b{valid,id,resp}  in  1/ID/2  observed B channel
axi_bready  out  1  constant 1
axi_r{valid,id,data,resp,last}  in  1/ID/DATA/2/1  observed R channel
axi_rready  out  1  constant 1
areq_{valid,write,id,addr,len,size,burst}  out  1/1/ID/ADDR/8/3/2  accepted address request
wreq_{valid,data,strb,last}  out  1/DATA/DATA/8/1  accepted W beat
w_if_cnt  out  $clog2(MAX_W_INFLIGHT)+1  outstanding writes
r_if_cnt  out  $clog2(MAX_R_INFLIGHT)+1  outstanding reads
err  out  3  sticky: [0] WLAST mismatch, [1] B underflow, [2] R underflow

Behaviour:
- Reset (async assert; deassert synchronous to clk): counters 0, len FIFO empty, beat counter 0, RR pointer = AW, err = 0. Outputs out of reset: areq_valid = 0, wreq_valid = 0, wready = 0, awready = 1 when awvalid is high, arready = 1 when arvalid is high.
- Eligibility: AW is eligible when w_if_cnt < MAX_W_INFLIGHT and the len FIFO is not full. AR is eligible when r_if_cnt < MAX_R_INFLIGHT.
- Grant: at most one grant per cycle, decided combinationally from valid and eligibility. awready/arready are high only for the granted channel. If both channels are eligible and valid: ARB_MODE=0 grants AW; ARB_MODE=1 grants the RR-pointer side, and the pointer flips to the other side after each grant. If only one channel is eligible, that channel is granted with no pointer penalty.
- areq_valid is high in the same cycle as the AW/AR handshake (zero latency). areq_write = 1 for AW; the payload is muxed from the granted channel.
- Len FIFO, depth MAX_W_INFLIGHT: push awlen on each AW handshake. axi_wready = FIFO non-empty at cycle start (no same-cycle bypass). wreq_valid = wvalid && wready, and wreq payload mirrors W.
- Beat counter (8 bit): increments on each W handshake. A burst ends on wlast or when beat == head len. At burst end: pop the FIFO, clear the counter, and set err[0] if wlast != (beat == head len).
- w_if_cnt: +1 on AW handshake, −1 on B handshake. r_if_cnt: +1 on AR handshake, −1 on an R handshake with rlast. A simultaneous +1/−1 nets zero.
- Underflow: a B handshake with w_if_cnt == 0 sets err[1] and the count holds at 0 (no wrap). An R-last handshake with r_if_cnt == 0 sets err[2] and the count holds.
- Full: when w_if_cnt == MAX_W_INFLIGHT, awready = 0, and a B handshake in the same cycle does not re-enable awready until the next cycle. AR behaves the same way.
- err bits are cleared only by reset.
- Reset asserted mid-burst drops all state immediately. There is no replay.

Decomposition:
- Package emulib_rammodel_pkg holds ARB_FIXED=0, ARB_RR=1, and the err bit indices ERR_WLAST=0, ERR_BUNDER=1, ERR_RUNDER=2.
- One sub-module, emulib_rammodel_len_fifo: a parametrised width/depth synchronous FIFO with async reset, exposing push/pop/full/empty/head.

Test Plan:
- AW len=3, then 4 W beats with wlast on beat 3 -> areq_valid pulses 1 cycle with write=1; wready=0 before the AW handshake; 4 wreq_valid pulses; err=0; w_if_cnt=1; after B, w_if_cnt=0.
- ARB_MODE=1 with AW and AR both valid continuously for 4 cycles -> grants alternate AW, AR, AW, AR. With ARB_MODE=0 -> AW on all 4 cycles.
- 8 ARs with no R (MAX_R_INFLIGHT=8) -> arready=0 on the 9th. R with rlast -> r_if_cnt 8→7, and the 9th AR is accepted the next cycle. AW is still accepted throughout.
- AW len=1, W with wlast on beat 0 -> err[0]=1 and stays set; the FIFO pops; the next AW/W burst proceeds normally.
- bvalid with no outstanding write -> err[1]=1 and w_if_cnt stays 0. rvalid+rlast with none outstanding -> err[2]=1.
- rst asserted mid-burst with w_if_cnt=3 -> all counters 0 and err=0 immediately (async); wready=0 until a new AW.

Source files
------------

// File: rtl/emulib_rammodel_pkg.sv
// Shared constants for the emulated RAM-model request tracker.
//   ARB_FIXED / ARB_RR : arbitration mode encodings for the ARB_MODE parameter
//   ERR_*              : bit positions inside the sticky err vector
package emulib_rammodel_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    localparam logic [1:0] ERR_WLAST  = 2'd0;
    localparam logic [1:0] ERR_BUNDER = 2'd1;
    localparam logic [1:0] ERR_RUNDER = 2'd2;

endpackage

// File: rtl/emulib_rammodel_len_fifo.sv
// Small synchronous FIFO holding the AWLEN of each accepted write burst.
//   clk, rst          : clock, asynchronous active-high reset
//   push, push_data   : write one entry (ignored when full)
//   pop               : drop the head entry (ignored when empty)
//   full, empty, head : status and oldest entry
module emulib_rammodel_len_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/emulib_rammodel_tracker_dual.sv
// AXI4 slave-side request tracker for the emulated RAM model.
// Merges AW/AR into one address-request stream, forwards W beats, limits
// outstanding reads and writes independently and flags protocol errors.
//   clk, rst                 : clock, asynchronous active-high reset
//   axi_aw* / axi_awready    : write address channel
//   axi_w*  / axi_wready     : write data channel
//   axi_ar* / axi_arready    : read address channel
//   axi_b*, axi_bready       : observed write response (always ready)
//   axi_r*, axi_rready       : observed read data (always ready)
//   areq_*                   : accepted address request (same cycle as handshake)
//   wreq_*                   : accepted W beat
//   w_if_cnt, r_if_cnt       : outstanding write / read transactions
//   err                      : sticky [0] WLAST mismatch, [1] B underflow, [2] R underflow
module emulib_rammodel_tracker_dual
    import emulib_rammodel_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned MAX_W_INFLIGHT = 8,
    parameter int unsigned MAX_R_INFLIGHT = 8,
    parameter int unsigned ARB_MODE       = ARB_RR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              axi_awvalid,
    input  logic [ID_WIDTH-1:0]               axi_awid,
    input  logic [ADDR_WIDTH-1:0]             axi_awaddr,
    input  logic [7:0]                        axi_awlen,
    input  logic [2:0]                        axi_awsize,
    input  logic [1:0]                        axi_awburst,
    output logic                              axi_awready,
    input  logic                              axi_wvalid,
    input  logic [DATA_WIDTH-1:0]             axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]           axi_wstrb,
    input  logic                              axi_wlast,
    output logic                              axi_wready,
    input  logic                              axi_arvalid,
    input  logic [ID_WIDTH-1:0]               axi_arid,
    input  logic [ADDR_WIDTH-1:0]             axi_araddr,
    input  logic [7:0]                        axi_arlen,
    input  logic [2:0]                        axi_arsize,
    input  logic [1:0]                        axi_arburst,
    output logic                              axi_arready,
    input  logic                              axi_bvalid,
    input  logic [ID_WIDTH-1:0]               axi_bid,
    input  logic [1:0]                        axi_bresp,
    output logic                              axi_bready,
    input  logic                              axi_rvalid,
    input  logic [ID_WIDTH-1:0]               axi_rid,
    input  logic [DATA_WIDTH-1:0]             axi_rdata,
    input  logic [1:0]                        axi_rresp,
    input  logic                              axi_rlast,
    output logic                              axi_rready,
    output logic                              areq_valid,
    output logic                              areq_write,
    output logic [ID_WIDTH-1:0]               areq_id,
    output logic [ADDR_WIDTH-1:0]             areq_addr,
    output logic [7:0]                        areq_len,
    output logic [2:0]                        areq_size,
    output logic [1:0]                        areq_burst,
    output logic                              wreq_valid,
    output logic [DATA_WIDTH-1:0]             wreq_data,
    output logic [DATA_WIDTH/8-1:0]           wreq_strb,
    output logic                              wreq_last,
    output logic [$clog2(MAX_W_INFLIGHT):0]   w_if_cnt,
    output logic [$clog2(MAX_R_INFLIGHT):0]   r_if_cnt,
    output logic [2:0]                        err
);

    localparam int unsigned WCW = $clog2(MAX_W_INFLIGHT) + 1;
    localparam int unsigned RCW = $clog2(MAX_R_INFLIGHT) + 1;

    logic       rr_ar;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       aw_req;
    logic       ar_req;
    logic       grant_aw;
    logic       grant_ar;
    logic [7:0] beat;
    logic       w_hs;
    logic       len_match;
    logic       burst_end;
    logic       w_dec;
    logic       r_dec;
    logic       b_under;
    logic       r_under;
    logic       unused_obs;

    assign unused_obs = ^{axi_bid, axi_bresp, axi_rid, axi_rdata, axi_rresp};

    assign axi_bready = 1'b1;
    assign axi_rready = 1'b1;

    // Eligibility uses registered counts only, so a same-cycle B/R cannot re-open a full side.
    assign aw_req = axi_awvalid && (w_if_cnt < WCW'(MAX_W_INFLIGHT)) && !fifo_full;
    assign ar_req = axi_arvalid && (r_if_cnt < RCW'(MAX_R_INFLIGHT));

    // Single grant per cycle; contention resolved by mode and RR pointer.
    always_comb begin
        grant_aw = 1'b0;
        grant_ar = 1'b0;
        if (aw_req && ar_req) begin
            if ((ARB_MODE == ARB_FIXED) || !rr_ar) begin
                grant_aw = 1'b1;
            end else begin
                grant_ar = 1'b1;
            end
        end else begin
            grant_aw = aw_req;
            grant_ar = ar_req;
        end
    end

    assign axi_awready = grant_aw;
    assign axi_arready = grant_ar;

    assign areq_valid = grant_aw || grant_ar;
    assign areq_write = grant_aw;
    assign areq_id    = grant_aw ? axi_awid    : axi_arid;
    assign areq_addr  = grant_aw ? axi_awaddr  : axi_araddr;
    assign areq_len   = grant_aw ? axi_awlen   : axi_arlen;
    assign areq_size  = grant_aw ? axi_awsize  : axi_arsize;
    assign areq_burst = grant_aw ? axi_awburst : axi_arburst;

    // W is accepted only against a burst already recorded in the len FIFO.
    assign axi_wready = !fifo_empty;
    assign w_hs       = axi_wvalid && axi_wready;
    assign wreq_valid = w_hs;
    assign wreq_data  = axi_wdata;
    assign wreq_strb  = axi_wstrb;
    assign wreq_last  = axi_wlast;

    assign len_match = (beat == fifo_head);
    assign burst_end = w_hs && (axi_wlast || len_match);

    emulib_rammodel_len_fifo #(
        .WIDTH (8),
        .DEPTH (MAX_W_INFLIGHT)
    ) u_len_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_aw),
        .push_data (axi_awlen),
        .pop       (burst_end),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A response with nothing outstanding is an underflow: flag it, keep the count at zero.
    assign b_under = axi_bvalid && (w_if_cnt == '0);
    assign r_under = axi_rvalid && axi_rlast && (r_if_cnt == '0);
    assign w_dec   = axi_bvalid && !b_under;
    assign r_dec   = axi_rvalid && axi_rlast && !r_under;

    // RR pointer points away from the side granted last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ar <= 1'b0;
        end else if (grant_aw) begin
            rr_ar <= 1'b1;
        end else if (grant_ar) begin
            rr_ar <= 1'b0;
        end
    end

    // Beat position within the current W burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
        end else if (burst_end) begin
            beat <= '0;
        end else if (w_hs) begin
            beat <= beat + 8'd1;
        end
    end

    // In-flight counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_if_cnt <= '0;
            r_if_cnt <= '0;
        end else begin
            case ({grant_aw, w_dec})
                2'b10:   w_if_cnt <= w_if_cnt + WCW'(1);
                2'b01:   w_if_cnt <= w_if_cnt - WCW'(1);
                default: w_if_cnt <= w_if_cnt;
            endcase
            case ({grant_ar, r_dec})
                2'b10:   r_if_cnt <= r_if_cnt + RCW'(1);
                2'b01:   r_if_cnt <= r_if_cnt - RCW'(1);
                default: r_if_cnt <= r_if_cnt;
            endcase
        end
    end

    // Sticky protocol error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= '0;
        end else begin
            if (burst_end && (axi_wlast != len_match)) begin
                err[ERR_WLAST] <= 1'b1;
            end
            if (b_under) begin
                err[ERR_BUNDER] <= 1'b1;
            end
            if (r_under) begin
                err[ERR_RUNDER] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_emulib_rammodel_tracker_dual.sv
// Self-checking bench for emulib_rammodel_tracker_dual: directed scenarios plus
// randomized traffic against a queue-based transaction model.
module tb_emulib_rammodel_tracker_dual;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 64;
    localparam int unsigned IW   = 4;
    localparam int unsigned MAXW = 8;
    localparam int unsigned MAXR = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic          axi_awvalid, axi_awready, axi_wvalid, axi_wlast, axi_wready;
    logic [IW-1:0] axi_awid, axi_arid, axi_bid, axi_rid;
    logic [AW-1:0] axi_awaddr, axi_araddr;
    logic [7:0]    axi_awlen, axi_arlen;
    logic [2:0]    axi_awsize, axi_arsize;
    logic [1:0]    axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic [DW-1:0] axi_wdata, axi_rdata;
    logic [DW/8-1:0] axi_wstrb;
    logic          axi_arvalid, axi_arready, axi_bvalid, axi_bready, axi_rvalid, axi_rlast, axi_rready;

    logic          areq_valid, areq_write, wreq_valid, wreq_last;
    logic [IW-1:0] areq_id;
    logic [AW-1:0] areq_addr;
    logic [7:0]    areq_len;
    logic [2:0]    areq_size;
    logic [1:0]    areq_burst;
    logic [DW-1:0] wreq_data;
    logic [DW/8-1:0] wreq_strb;
    logic [3:0]    w_if_cnt, r_if_cnt;
    logic [2:0]    err;

    // Fixed-priority instance, same stimulus
    logic          f_awready, f_wready, f_arready, f_bready, f_rready;
    logic          f_areq_valid, f_areq_write, f_wreq_valid, f_wreq_last;
    logic [IW-1:0] f_areq_id;
    logic [AW-1:0] f_areq_addr;
    logic [7:0]    f_areq_len;
    logic [2:0]    f_areq_size;
    logic [1:0]    f_areq_burst;
    logic [DW-1:0] f_wreq_data;
    logic [DW/8-1:0] f_wreq_strb;
    logic [3:0]    f_w_if_cnt, f_r_if_cnt;
    logic [2:0]    f_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int       m_wcnt;
    int       m_rcnt;
    int       m_beat;
    int       m_lenq[$];
    bit       m_rr_ar;
    logic [2:0] m_err;

    logic seen_awready, seen_arready, seen_wready, seen_wreq_valid, seen_f_awready, seen_f_arready;

    always #5 clk = ~clk;

    emulib_rammodel_tracker_dual #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_W_INFLIGHT(MAXW), .MAX_R_INFLIGHT(MAXR), .ARB_MODE(1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wready(axi_wready),
        .axi_arvalid(axi_arvalid), .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arready(axi_arready),
        .axi_bvalid(axi_bvalid), .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
        .axi_rvalid(axi_rvalid), .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rready(axi_rready),
        .areq_valid(areq_valid), .areq_write(areq_write), .areq_id(areq_id), .areq_addr(areq_addr),
        .areq_len(areq_len), .areq_size(areq_size), .areq_burst(areq_burst),
        .wreq_valid(wreq_valid), .wreq_data(wreq_data), .wreq_strb(wreq_strb), .wreq_last(wreq_last),
        .w_if_cnt(w_if_cnt), .r_if_cnt(r_if_cnt), .err(err)
    );

    emulib_rammodel_tracker_dual #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_W_INFLIGHT(MAXW), .MAX_R_INFLIGHT(MAXR), .ARB_MODE(0)
    ) u_dut_fixed (
        .clk(clk), .rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awready(f_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wready(f_wready),
        .axi_arvalid(axi_arvalid), .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arready(f_arready),
        .axi_bvalid(axi_bvalid), .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bready(f_bready),
        .axi_rvalid(axi_rvalid), .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rready(f_rready),
        .areq_valid(f_areq_valid), .areq_write(f_areq_write), .areq_id(f_areq_id), .areq_addr(f_areq_addr),
        .areq_len(f_areq_len), .areq_size(f_areq_size), .areq_burst(f_areq_burst),
        .wreq_valid(f_wreq_valid), .wreq_data(f_wreq_data), .wreq_strb(f_wreq_strb), .wreq_last(f_wreq_last),
        .w_if_cnt(f_w_if_cnt), .r_if_cnt(f_r_if_cnt), .err(f_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        axi_awvalid = 1'b0; axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
        axi_wvalid  = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0;
        axi_arvalid = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0;
        axi_bvalid  = 1'b0; axi_bid = '0; axi_bresp = '0;
        axi_rvalid  = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
    endtask

    task automatic model_clear();
        m_wcnt = 0; m_rcnt = 0; m_beat = 0; m_lenq.delete(); m_rr_ar = 1'b0; m_err = 3'b000;
    endtask

    // Compare every output against the model for the current inputs, then advance the model.
    task automatic check_and_update();
        bit gaw, gar, aw_el, ar_el, last_exp;
        int wc0, rc0;
        aw_el = (m_wcnt < MAXW) && (m_lenq.size() < MAXW);
        ar_el = (m_rcnt < MAXR);
        gaw   = axi_awvalid && aw_el && !(axi_arvalid && ar_el && m_rr_ar);
        gar   = axi_arvalid && ar_el && !gaw;

        check("awready", 64'(axi_awready), 64'(gaw));
        check("arready", 64'(axi_arready), 64'(gar));
        check("areq_valid", 64'(areq_valid), 64'(gaw || gar));
        if (gaw || gar) begin
            check("areq_write", 64'(areq_write), 64'(gaw));
            check("areq_id",    64'(areq_id),    64'(gaw ? axi_awid : axi_arid));
            check("areq_addr",  64'(areq_addr),  64'(gaw ? axi_awaddr : axi_araddr));
            check("areq_len",   64'(areq_len),   64'(gaw ? axi_awlen : axi_arlen));
            check("areq_size",  64'(areq_size),  64'(gaw ? axi_awsize : axi_arsize));
            check("areq_burst", 64'(areq_burst), 64'(gaw ? axi_awburst : axi_arburst));
        end
        check("wready", 64'(axi_wready), 64'(m_lenq.size() > 0));
        check("wreq_valid", 64'(wreq_valid), 64'(axi_wvalid && (m_lenq.size() > 0)));
        if (axi_wvalid && (m_lenq.size() > 0)) begin
            check("wreq_data", 64'(wreq_data), 64'(axi_wdata));
            check("wreq_strb", 64'(wreq_strb), 64'(axi_wstrb));
            check("wreq_last", 64'(wreq_last), 64'(axi_wlast));
        end
        check("w_if_cnt", 64'(w_if_cnt), 64'(m_wcnt));
        check("r_if_cnt", 64'(r_if_cnt), 64'(m_rcnt));
        check("err", 64'(err), 64'(m_err));
        check("bready", 64'(axi_bready & axi_rready), 64'd1);

        seen_awready    = axi_awready;
        seen_arready    = axi_arready;
        seen_wready     = axi_wready;
        seen_wreq_valid = wreq_valid;
        seen_f_awready  = f_awready;
        seen_f_arready  = f_arready;

        wc0 = m_wcnt;
        rc0 = m_rcnt;
        if (axi_wvalid && (m_lenq.size() > 0)) begin
            last_exp = (m_beat == m_lenq[0]);
            if (axi_wlast || last_exp) begin
                if (axi_wlast != last_exp) m_err[0] = 1'b1;
                void'(m_lenq.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (gaw) begin
            m_lenq.push_back(int'(axi_awlen));
            m_rr_ar = 1'b1;
        end
        if (gar) m_rr_ar = 1'b0;
        if (axi_bvalid) begin
            if (wc0 == 0) m_err[1] = 1'b1;
            else m_wcnt--;
        end
        if (gaw) m_wcnt++;
        if (axi_rvalid && axi_rlast) begin
            if (rc0 == 0) m_err[2] = 1'b1;
            else m_rcnt--;
        end
        if (gar) m_rcnt++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    // Async reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        check("rst_w_if_cnt", 64'(w_if_cnt), 64'd0);
        check("rst_r_if_cnt", 64'(r_if_cnt), 64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_wready",   64'(axi_wready), 64'd0);
        check("rst_areq",     64'(areq_valid), 64'd0);
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive_random();
        axi_awvalid = ($urandom_range(0, 1) == 1);
        axi_awid    = IW'($urandom);
        axi_awaddr  = AW'($urandom);
        axi_awlen   = 8'($urandom_range(0, 3));
        axi_awsize  = 3'($urandom);
        axi_awburst = 2'($urandom);
        axi_arvalid = ($urandom_range(0, 1) == 1);
        axi_arid    = IW'($urandom);
        axi_araddr  = AW'($urandom);
        axi_arlen   = 8'($urandom);
        axi_arsize  = 3'($urandom);
        axi_arburst = 2'($urandom);
        axi_wvalid  = ($urandom_range(0, 2) != 0);
        axi_wdata   = {$urandom, $urandom};
        axi_wstrb   = 8'($urandom);
        axi_wlast   = (m_lenq.size() > 0) && (m_beat == m_lenq[0]);
        if ($urandom_range(0, 15) == 0) axi_wlast = !axi_wlast;
        axi_bvalid  = (m_wcnt > 0) && ($urandom_range(0, 3) == 0);
        axi_bid     = IW'($urandom);
        axi_rvalid  = (m_rcnt > 0) && ($urandom_range(0, 2) == 0);
        axi_rlast   = ($urandom_range(0, 1) == 1);
        axi_rid     = IW'($urandom);
        axi_rdata   = {$urandom, $urandom};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        drive_idle();
        model_clear();
        #2;
        do_reset();

        // Single write burst: len=3, four beats, then B
        axi_awvalid = 1'b1; axi_awid = 4'd5; axi_awaddr = 32'h1000; axi_awlen = 8'd3;
        axi_awsize = 3'd3; axi_awburst = 2'd1;
        axi_wvalid = 1'b1; axi_wdata = 64'hA5; axi_wstrb = 8'hFF;
        run_cycle();
        check("t1_aw_grant", 64'(seen_awready), 64'd1);
        check("t1_wready_before_aw", 64'(seen_wready), 64'd0);
        axi_awvalid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            axi_wdata = 64'(i) + 64'h100;
            axi_wlast = (i == 3);
            run_cycle();
            if (seen_wreq_valid) pulses++;
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        check("t1_wreq_pulses", 64'(pulses), 64'd4);
        check("t1_w_if_cnt", 64'(w_if_cnt), 64'd1);
        check("t1_err", 64'(err), 64'd0);
        axi_bvalid = 1'b1;
        run_cycle();
        axi_bvalid = 1'b0;
        check("t1_w_if_cnt_after_b", 64'(w_if_cnt), 64'd0);

        // Arbitration with both channels valid for four cycles
        do_reset();
        axi_awvalid = 1'b1; axi_awlen = 8'd0; axi_awaddr = 32'h2000;
        axi_arvalid = 1'b1; axi_arlen = 8'd7; axi_araddr = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check("t2_rr_aw", 64'(seen_awready), 64'((i % 2) == 0));
            check("t2_rr_ar", 64'(seen_arready), 64'((i % 2) == 1));
            check("t2_fixed_aw", 64'(seen_f_awready), 64'd1);
            check("t2_fixed_ar", 64'(seen_f_arready), 64'd0);
        end
        drive_idle();

        // Read limit: eight ARs fill the read side
        do_reset();
        axi_arvalid = 1'b1; axi_araddr = 32'h4000;
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            check("t3_ar_accept", 64'(seen_arready), 64'd1);
        end
        check("t3_r_full", 64'(r_if_cnt), 64'd8);
        axi_awvalid = 1'b1; axi_awlen = 8'd0;
        run_cycle();
        check("t3_ar_blocked", 64'(seen_arready), 64'd0);
        check("t3_aw_still_ok", 64'(seen_awready), 64'd1);
        axi_awvalid = 1'b0;
        axi_rvalid = 1'b1; axi_rlast = 1'b1;
        run_cycle();
        check("t3_ar_blocked_same_cycle", 64'(seen_arready), 64'd0);
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        check("t3_r_after_rlast", 64'(r_if_cnt), 64'd7);
        run_cycle();
        check("t3_ar_reaccept", 64'(seen_arready), 64'd1);
        drive_idle();

        // Underflow flags, then a WLAST mismatch without intervening reset
        do_reset();
        axi_bvalid = 1'b1;
        run_cycle();
        axi_bvalid = 1'b0;
        check("t5_b_under", 64'(err), 64'b010);
        check("t5_w_hold", 64'(w_if_cnt), 64'd0);
        axi_rvalid = 1'b1; axi_rlast = 1'b1;
        run_cycle();
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        check("t5_r_under", 64'(err), 64'b110);
        check("t5_r_hold", 64'(r_if_cnt), 64'd0);
        axi_awvalid = 1'b1; axi_awlen = 8'd1;
        run_cycle();
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b1; axi_wlast = 1'b1;
        run_cycle();
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        check("t4_wlast_err", 64'(err), 64'b111);
        check("t4_fifo_popped", 64'(axi_wready), 64'd0);
        axi_awvalid = 1'b1; axi_awlen = 8'd0;
        run_cycle();
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b1; axi_wlast = 1'b1;
        run_cycle();
        drive_idle();
        check("t4_err_sticky", 64'(err), 64'b111);
        check("t4_w_if_cnt", 64'(w_if_cnt), 64'd2);

        // Reset in the middle of a burst
        do_reset();
        axi_awvalid = 1'b1; axi_awlen = 8'd3;
        for (int i = 0; i < 3; i++) run_cycle();
        axi_awvalid = 1'b0;
        axi_wvalid = 1'b1;
        for (int i = 0; i < 2; i++) run_cycle();
        check("t6_pre_rst_cnt", 64'(w_if_cnt), 64'd3);
        #2;
        do_reset();
        axi_wvalid = 1'b1;
        run_cycle();
        check("t6_wready_after_rst", 64'(seen_wready), 64'd0);
        drive_idle();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive_random();
            run_cycle();
        end
        drive_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
